// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: one round key per clock through a
// single shared g-function, results kept in an indexed round-key store.
//
// state  | meaning
// IDLE   | no key since reset; waiting for key_valid
// EXPAND | producing rk[cnt] each clock; new keys are refused
// DONE   | all round keys valid; a new key restarts the expansion

module aes_key_sched_ctrl #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             busy,
  output logic             ks_ready,
  output logic             done,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic             rd_err,
  output logic [127:0]     rd_data
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_key_sched_ctrl: only NR=10 (AES-128) is supported");
  end
  if ((2 ** IDX_W) <= NR) begin : g_bad_idx_w
    $error("aes_key_sched_ctrl: IDX_W too narrow to index NR+1 round keys");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // AES S-box, byte 0x00 in the top byte of the constant
  localparam logic [2047:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] pos;
    pos = {~a, 3'b000};
    return SBOX[pos +: 8];
  endfunction

  state_t           state, state_nxt;
  logic             accept, expand_last;
  logic [IDX_W-1:0] cnt;
  logic [7:0]       rcon, rcon_nxt;
  logic [127:0]     prev_rk, next_rk;
  logic [127:0]     rk [0:NR];
  logic [NR:0]      rk_vld;
  logic [31:0]      rot, sub, g;
  logic [31:0]      w0, w1, w2, w3;
  logic             idx_in_range, rd_hit;
  logic [IDX_W-1:0] rd_sel;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, handshake and status decode
  always_comb begin
    state_nxt   = state;
    key_ready   = 1'b0;
    busy        = 1'b0;
    ks_ready    = 1'b0;
    accept      = 1'b0;
    expand_last = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        accept    = key_valid;
        if (key_valid) state_nxt = EXPAND;
      end
      EXPAND: begin
        busy        = 1'b1;
        expand_last = (cnt == LAST_IDX);
        if (expand_last) state_nxt = DONE;
      end
      DONE: begin
        key_ready = 1'b1;
        ks_ready  = 1'b1;
        accept    = key_valid;
        if (key_valid) state_nxt = EXPAND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // prev_rk mirrors rk[cnt-1] so the g-path never reads the store array
  assign rot = {prev_rk[23:0], prev_rk[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
  end
  assign g        = sub ^ {rcon, 24'h0};
  assign w0       = prev_rk[127:96] ^ g;
  assign w1       = w0 ^ prev_rk[95:64];
  assign w2       = w1 ^ prev_rk[63:32];
  assign w3       = w2 ^ prev_rk[31:0];
  assign next_rk  = {w0, w1, w2, w3};
  assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  // Round-key store contents (validity is tracked separately)
  always_ff @(posedge clk) begin
    if (accept)    rk[0]   <= key_in;
    else if (busy) rk[cnt] <= next_rk;
  end

  // Expansion counter, round constant, validity flags and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      rcon    <= 8'h01;
      prev_rk <= '0;
      rk_vld  <= '0;
      done    <= 1'b0;
    end else begin
      done <= expand_last;
      if (accept) begin
        cnt     <= IDX_ONE;
        rcon    <= 8'h01;
        prev_rk <= key_in;
        rk_vld  <= {{NR{1'b0}}, 1'b1};
      end else if (busy) begin
        prev_rk     <= next_rk;
        rk_vld[cnt] <= 1'b1;
        rcon        <= rcon_nxt;
        if (!expand_last) cnt <= cnt + IDX_ONE;
      end
    end
  end

  // Reads see the store as it was before this edge's write or rekey
  assign idx_in_range = (rd_idx <= LAST_IDX);
  assign rd_sel       = idx_in_range ? rd_idx : '0;
  assign rd_hit       = idx_in_range && rk_vld[rd_sel];

  // Registered read port; rd_data keeps its last value on an error
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en & rd_hit;
      rd_err   <= rd_en & ~rd_hit;
      if (rd_en && rd_hit) rd_data <= rk[rd_sel];
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: known-answer vectors, directed corner sequences
// and randomized traffic checked against a word-level FIPS-197 expansion model.
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready, busy, ks_ready, done;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_idx = '0;
  logic         rd_valid, rd_err;
  logic [127:0] rd_data;

  aes_key_sched_ctrl #(.NR(10), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .busy(busy), .ks_ready(ks_ready), .done(done),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_err(rd_err),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic [127:0] exp;
  } kat_t;
  kat_t kat [6];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int edge_n    = 0;

  logic [7:0]   sb [256];
  logic [127:0] mdl_rk [11];
  bit           mdl_have = 1'b0;
  int           mdl_acc  = 0;
  logic [127:0] mdl_last = '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv; s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t  = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_valid = 1'b0; rd_en = 1'b0;
    tick();
    check("reset_status{kr,busy,ksr,done,rv,rerr}",
          128'({key_ready, busy, ks_ready, done, rd_valid, rd_err}), 128'(6'b100000));
    check("reset_rd_data", rd_data, 128'd0);
    rst = 1'b0;
    mdl_have = 1'b0;
    mdl_last = '0;
  endtask

  // One clock edge with the given inputs; every output is checked against the model
  task automatic step(input bit kv, input logic [127:0] key, input bit re, input logic [3:0] idx);
    int e, age;
    bit expanding, hit, acc;
    logic [5:0] exp_st;
    e   = edge_n + 1;
    age = e - mdl_acc;
    hit = re && mdl_have && (int'(idx) <= 10) && (age > int'(idx));
    if (hit) mdl_last = mdl_rk[idx];
    expanding = mdl_have && (age <= 10);
    acc = kv && !expanding;
    if (acc) begin
      mdl_have = 1'b1;
      mdl_acc  = e;
      model_expand(key);
    end
    age = e - mdl_acc;
    exp_st = {!(mdl_have && age < 10), mdl_have && age < 10, mdl_have && age >= 10,
              mdl_have && age == 10, hit, re && !hit};
    key_valid = kv; key_in = key; rd_en = re; rd_idx = idx;
    tick();
    key_valid = 1'b0; rd_en = 1'b0;
    check("status{kr,busy,ksr,done,rv,rerr}",
          128'({key_ready, busy, ks_ready, done, rd_valid, rd_err}), 128'(exp_st));
    check("rd_data", rd_data, mdl_last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 4'd0);
  endtask

  initial begin
    kat[0] = '{FIPS_KEY, 4'd1,  FIPS_R1};
    kat[1] = '{FIPS_KEY, 4'd10, FIPS_R10};
    kat[2] = '{FIPS_KEY, 4'd0,  FIPS_KEY};
    kat[3] = '{128'd0,   4'd1,  ZERO_R1};
    kat[4] = '{128'd0,   4'd10, ZERO_R10};
    kat[5] = '{FIPS_KEY, 4'd3,  FIPS_R3};

    build_sbox();
    do_reset();

    // Nothing computed yet: reads fail
    step(1'b0, '0, 1'b1, 4'd0);
    check("idle_rd_err", 128'(rd_err), 128'(1));

    // Known-answer vectors: full expansion then read one index
    for (int i = 0; i < 6; i++) begin
      step(1'b1, kat[i].key, 1'b0, 4'd0);
      idle(9);
      step(1'b0, '0, 1'b0, 4'd0);
      check("kat_done_at_T10", 128'(done), 128'(1));
      step(1'b0, '0, 1'b1, kat[i].idx);
      check($sformatf("kat%0d_rd_data", i), rd_data, kat[i].exp);
    end

    // Early consumption and ignored key during EXPAND
    step(1'b1, FIPS_KEY, 1'b0, 4'd0);
    step(1'b0, '0, 1'b0, 4'd0);
    step(1'b0, '0, 1'b1, 4'd3);
    check("early_idx3_rd_err", 128'(rd_err), 128'(1));
    step(1'b0, '0, 1'b0, 4'd0);
    step(1'b0, '0, 1'b1, 4'd3);
    check("early_idx3_rd_data", rd_data, FIPS_R3);
    step(1'b1, 128'd0, 1'b0, 4'd0);
    idle(4);
    step(1'b0, '0, 1'b0, 4'd0);
    check("no_accept_done", 128'(done), 128'(1));
    step(1'b0, '0, 1'b1, 4'd10);
    check("no_accept_idx10", rd_data, FIPS_R10);

    // Out-of-range indices in DONE
    step(1'b0, '0, 1'b1, 4'd11);
    check("idx11_err_valid", 128'({rd_err, rd_valid}), 128'(2'b10));
    step(1'b0, '0, 1'b1, 4'd15);
    check("idx15_err_valid", 128'({rd_err, rd_valid}), 128'(2'b10));
    step(1'b0, '0, 1'b1, 4'd0);
    check("idx0_orig_key", rd_data, FIPS_KEY);

    // Reset in the middle of an expansion
    step(1'b1, 128'd0, 1'b0, 4'd0);
    idle(4);
    do_reset();
    step(1'b0, '0, 1'b1, 4'd2);
    check("post_rst_idx2_err", 128'(rd_err), 128'(1));
    step(1'b1, FIPS_KEY, 1'b0, 4'd0);
    idle(10);
    for (int i = 0; i <= 10; i++) step(1'b0, '0, 1'b1, 4'(i));
    check("post_rst_idx10", rd_data, FIPS_R10);

    // Rekey in DONE under back-to-back reads of idx10
    step(1'b0, '0, 1'b1, 4'd10);
    step(1'b0, '0, 1'b1, 4'd10);
    step(1'b1, 128'd0, 1'b1, 4'd10);
    check("rekey_edge_old_key", rd_data, FIPS_R10);
    check("rekey_edge_valid", 128'(rd_valid), 128'(1));
    for (int i = 1; i <= 10; i++) step(1'b0, '0, 1'b1, 4'd10);
    check("rekey_T10_err", 128'(rd_err), 128'(1));
    step(1'b0, '0, 1'b1, 4'd10);
    check("rekey_new_idx10", rd_data, ZERO_R10);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else step($urandom_range(0, 11) == 0,
                {$urandom(), $urandom(), $urandom(), $urandom()},
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
